// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand request side and result side.
interface serial_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle ripple adder/subtractor: DIGIT bits per clock, registered
// carry between digits, valid/ready on both operand and result sides.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   slice_full;
  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] sum_sr_nxt;

  // DIGIT-bit full-adder slice on the low operand digits; the carry into the
  // slice MSB is recovered from the MSB sum bit for the overflow flag.
  always_comb begin
    slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    slice_s    = slice_full[DIGIT-1:0];
    slice_cout = slice_full[DIGIT];
    slice_cmsb = slice_s[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    sum_sr_nxt = (sum_sr_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
  end

  // Next-state: accept in IDLE, one digit per RUN edge, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.c_in ^ bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        sum_sr_d = sum_sr_nxt;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          sum_d   = sum_sr_nxt;
          c_out_d = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases on the default
// configuration plus a random sweep across four WIDTH/DIGIT configurations.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) if_d1  ();
  serial_adder_if #(.WIDTH(16)) if_d4  ();
  serial_adder_if #(.WIDTH(16)) if_d16 ();
  serial_adder_if #(.WIDTH(8))  if_w8  ();

  serial_adder #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .bus(if_d1.slave));
  serial_adder #(.WIDTH(16), .DIGIT(4))  u_d4  (.clk(clk), .rst(rst), .bus(if_d4.slave));
  serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .bus(if_d16.slave));
  serial_adder #(.WIDTH(8),  .DIGIT(2))  u_w8  (.clk(clk), .rst(rst), .bus(if_w8.slave));

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sbq[4][$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // per-config views: 0 = 16/1, 1 = 16/4, 2 = 16/16, 3 = 8/2
  logic [15:0] osum [4];
  logic        ovld [4];
  logic        oco  [4];
  logic        oov  [4];
  assign osum[0] = if_d1.sum;         assign ovld[0] = if_d1.out_valid;
  assign osum[1] = if_d4.sum;         assign ovld[1] = if_d4.out_valid;
  assign osum[2] = if_d16.sum;        assign ovld[2] = if_d16.out_valid;
  assign osum[3] = {8'h00, if_w8.sum}; assign ovld[3] = if_w8.out_valid;
  assign oco[0] = if_d1.c_out;  assign oov[0] = if_d1.overflow;
  assign oco[1] = if_d4.c_out;  assign oov[1] = if_d4.overflow;
  assign oco[2] = if_d16.c_out; assign oov[2] = if_d16.overflow;
  assign oco[3] = if_w8.c_out;  assign oov[3] = if_w8.overflow;

  // Arithmetic reference: unsigned result for sum/carry, signed range for overflow.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    longint mask, half, ua, ub, sa, sb, r, sr;
    exp_t e;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - (mask + 1) : ua;
    sb = (ub >= half) ? ub - (mask + 1) : ub;
    if (sub) begin
      r  = ua - ub - longint'(cin);
      sr = sa - sb - longint'(cin);
      e.co = (r >= 0);
    end else begin
      r  = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      e.co = (r > mask);
    end
    e.s  = 16'(r & mask);
    e.ov = (sr >= half) || (sr < -half);
    return e;
  endfunction

  task automatic idle_all();
    if_d1.in_valid = 0;  if_d1.out_ready = 0;  if_d1.a = 0;  if_d1.b = 0;  if_d1.c_in = 0;  if_d1.sub = 0;
    if_d4.in_valid = 0;  if_d4.out_ready = 0;  if_d4.a = 0;  if_d4.b = 0;  if_d4.c_in = 0;  if_d4.sub = 0;
    if_d16.in_valid = 0; if_d16.out_ready = 0; if_d16.a = 0; if_d16.b = 0; if_d16.c_in = 0; if_d16.sub = 0;
    if_w8.in_valid = 0;  if_w8.out_ready = 0;  if_w8.a = 0;  if_w8.b = 0;  if_w8.c_in = 0;  if_w8.sub = 0;
  endtask

  // Drive one operation into the 16/4 instance and queue its expected result.
  task automatic start_main(logic [15:0] a, logic [15:0] b, logic cin, logic sub, exp_t e);
    sbq[1].push_back(e);
    if_d4.a = a; if_d4.b = b; if_d4.c_in = cin; if_d4.sub = sub;
    if_d4.in_valid = 1;
    @(posedge clk); #1;
    if_d4.in_valid = 0;
  endtask

  task automatic wait_main(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if_d4.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake_main();
    if_d4.out_ready = 1;
    @(posedge clk); #1;
    if_d4.out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if_d4.in_ready !== 1'b1 || if_d4.out_valid !== 1'b0) $display("FAIL reset_handshake in_ready=%b out_valid=%b want 1/0", if_d4.in_ready, if_d4.out_valid);
    else n_pass++;
    n_checks++;
    if (if_d4.sum !== 16'h0 || if_d4.c_out !== 1'b0 || if_d4.overflow !== 1'b0) $display("FAIL reset_outputs sum=%h c_out=%b ovf=%b want 0000/0/0", if_d4.sum, if_d4.c_out, if_d4.overflow);
    else n_pass++;
    n_checks++;
    if (if_d1.in_ready !== 1'b1 || if_d16.in_ready !== 1'b1 || if_w8.in_ready !== 1'b1) $display("FAIL reset_others in_ready=%b%b%b want 111", if_d1.in_ready, if_d16.in_ready, if_w8.in_ready);
    else n_pass++;
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        tsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t        te [5] = '{{16'h5555, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                            {16'hFFFE, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1}};
    int   lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      start_main(ta[i], tb[i], 1'b0, tsub[i], te[i]);
      n_checks++;
      if (if_d4.in_ready !== 1'b0) $display("FAIL arith%0d_busy in_ready=%b want 0", i, if_d4.in_ready);
      else n_pass++;
      wait_main(lat);
      n_checks++;
      if (lat !== 4) $display("FAIL arith%0d_latency got %0d want 4", i, lat);
      else n_pass++;
      if (sbq[1].size() > 0) begin
        e = sbq[1].pop_front();
        n_checks++;
        if ({if_d4.sum, if_d4.c_out, if_d4.overflow} !== {e.s, e.co, e.ov})
          $display("FAIL arith%0d_result sum/co/ov=%h/%b/%b want %h/%b/%b", i, if_d4.sum, if_d4.c_out, if_d4.overflow, e.s, e.co, e.ov);
        else n_pass++;
      end
      handshake_main();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    start_main(16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
    wait_main(lat);
    e = sbq[1].pop_front();
    n_checks++;
    if (lat !== 4 || if_d4.sum !== e.s) $display("FAIL bp_first lat=%0d sum=%h want 4/%h", lat, if_d4.sum, e.s);
    else n_pass++;
    if_d4.a = 16'hFFFF; if_d4.b = 16'hFFFF; if_d4.c_in = 1; if_d4.sub = 0;
    if_d4.in_valid = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if_d4.sum !== e.s || if_d4.c_out !== e.co || if_d4.overflow !== e.ov ||
          if_d4.in_ready !== 1'b0 || if_d4.out_valid !== 1'b1)
        $display("FAIL bp_hold%0d sum=%h co=%b ov=%b in_ready=%b out_valid=%b want %h/%b/%b/0/1",
                 k, if_d4.sum, if_d4.c_out, if_d4.overflow, if_d4.in_ready, if_d4.out_valid, e.s, e.co, e.ov);
      else n_pass++;
    end
    if_d4.in_valid = 0;
    handshake_main();
    n_checks++;
    if (if_d4.in_ready !== 1'b1 || if_d4.out_valid !== 1'b0 || if_d4.sum !== e.s)
      $display("FAIL bp_release in_ready=%b out_valid=%b sum=%h want 1/0/%h", if_d4.in_ready, if_d4.out_valid, if_d4.sum, e.s);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if_d4.in_ready !== 1'b1) $display("FAIL bp_not_taken in_ready=%b want 1", if_d4.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   lat;
    int   seen;
    exp_t e;
    start_main(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sbq[1].delete();
    n_checks++;
    if (if_d4.in_ready !== 1'b1 || if_d4.out_valid !== 1'b0 || if_d4.sum !== 16'h0)
      $display("FAIL rstmid_state in_ready=%b out_valid=%b sum=%h want 1/0/0000", if_d4.in_ready, if_d4.out_valid, if_d4.sum);
    else n_pass++;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if_d4.out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL rstmid_no_valid got %0d valid cycles want 0", seen);
    else n_pass++;
    start_main(16'h0003, 16'h0004, 1'b1, 1'b0, '{16'h0008, 1'b0, 1'b0});
    wait_main(lat);
    n_checks++;
    if (lat !== 4) $display("FAIL rstmid_latency got %0d want 4", lat);
    else n_pass++;
    if (sbq[1].size() > 0) begin
      e = sbq[1].pop_front();
      n_checks++;
      if ({if_d4.sum, if_d4.c_out, if_d4.overflow} !== {e.s, e.co, e.ov})
        $display("FAIL rstmid_result sum/co/ov=%h/%b/%b want %h/%b/%b", if_d4.sum, if_d4.c_out, if_d4.overflow, e.s, e.co, e.ov);
      else n_pass++;
    end
    handshake_main();
  endtask

  task automatic test_sweep();
    int   wd   [4] = '{16, 16, 16, 8};
    int   nexp [4] = '{16, 4, 1, 4};
    int   lat  [4];
    bit   got  [4];
    exp_t e;
    logic [15:0] va, vb;
    logic        vc, vs;
    for (int v = 0; v < 1000; v++) begin
      va = 16'($urandom);
      vb = 16'($urandom);
      vc = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      for (int d = 0; d < 4; d++) begin
        sbq[d].push_back(model(wd[d], va, vb, vc, vs));
        got[d] = 0;
        lat[d] = -1;
      end
      if_d1.a = va;        if_d1.b = vb;        if_d1.c_in = vc;  if_d1.sub = vs;  if_d1.in_valid = 1;
      if_d4.a = va;        if_d4.b = vb;        if_d4.c_in = vc;  if_d4.sub = vs;  if_d4.in_valid = 1;
      if_d16.a = va;       if_d16.b = vb;       if_d16.c_in = vc; if_d16.sub = vs; if_d16.in_valid = 1;
      if_w8.a = va[7:0];   if_w8.b = vb[7:0];   if_w8.c_in = vc;  if_w8.sub = vs;  if_w8.in_valid = 1;
      @(posedge clk); #1;
      if_d1.in_valid = 0; if_d4.in_valid = 0; if_d16.in_valid = 0; if_w8.in_valid = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
          if (!got[d] && ovld[d]) begin
            got[d] = 1;
            lat[d] = k;
            e = sbq[d].pop_front();
            n_checks++;
            if (k !== nexp[d]) $display("FAIL sweep%0d_latency vec %0d got %0d want %0d", d, v, k, nexp[d]);
            else n_pass++;
            n_checks++;
            if ({osum[d], oco[d], oov[d]} !== {e.s, e.co, e.ov})
              $display("FAIL sweep%0d_result vec %0d a=%h b=%h cin=%b sub=%b got %h/%b/%b want %h/%b/%b",
                       d, v, va, vb, vc, vs, osum[d], oco[d], oov[d], e.s, e.co, e.ov);
            else n_pass++;
          end
        end
        if (got[0] && got[1] && got[2] && got[3]) break;
      end
      for (int d = 0; d < 4; d++) begin
        if (!got[d]) begin
          n_checks++;
          $display("FAIL sweep%0d_timeout vec %0d no out_valid within 20 cycles", d, v);
          sbq[d].delete();
        end
      end
      if_d1.out_ready = 1; if_d4.out_ready = 1; if_d16.out_ready = 1; if_w8.out_ready = 1;
      @(posedge clk); #1;
      if_d1.out_ready = 0; if_d4.out_ready = 0; if_d16.out_ready = 0; if_w8.out_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
